// File: rtl/pipe_ctrl.sv
// Pipeline control: priority stall resolution, branch redirect sequencing, stall watchdog.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int ADDR_W   = 17,
  parameter int WD_LIMIT = 1024,
  parameter int WD_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [5:0]        stall,
  output logic              flush_if,
  output logic              flush_id,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_addr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              hang
);

  typedef enum logic {RUN, WAIT_IF} state_t;

  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] tgt_q;
  logic [WD_W-1:0]   wd_cnt;
  logic [5:0]        base;
  logic              take_br;

  always_comb begin
    if (stallreq_mem)      base = 6'b011111;
    else if (stallreq_ex)  base = 6'b001111;
    else if (stallreq_id)  base = 6'b000111;
    else if (stallreq_if)  base = 6'b000011;
    else                   base = 6'b000000;
  end

  // A branch is only honoured when EX is not held; a held EX re-presents it later.
  assign take_br = (state == RUN) && branch_flag && !base[3];

  always_comb begin
    stall         = base;
    flush_if      = 1'b0;
    flush_id      = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = '0;
    if (rst) begin
      stall = '0;
    end else if (state == WAIT_IF) begin
      stall    = base | 6'b000001;
      flush_if = 1'b1;
      if (!stallreq_if) begin
        pc_redirect   = 1'b1;
        redirect_addr = tgt_q;
      end
    end else if (take_br) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
      if (!stallreq_if) begin
        pc_redirect   = 1'b1;
        redirect_addr = branch_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      tgt_q  <= '0;
      wd_cnt <= '0;
      hang   <= 1'b0;
    end else begin
      case (state)
        RUN: if (take_br && stallreq_if) begin
          tgt_q <= branch_target;
          state <= WAIT_IF;
        end
        WAIT_IF: if (!stallreq_if) state <= RUN;
        default: state <= RUN;
      endcase
      if (stall[0]) begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_LAST) hang <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall[0])    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
